// File: rtl/time_lock_pkg.sv
// Shared types for the multi-stage time-lock sequencer.
// Encodings outside the named states are treated as LOCKOUT by the FSM.
package time_lock_pkg;

    localparam int unsigned TL_STATE_W = 3;

    typedef enum logic [TL_STATE_W-1:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        DONE    = 3'd2,
        FAIL    = 3'd3,
        LOCKOUT = 3'd4
    } tl_state_e;

endpackage

// File: rtl/dwell_timer.sv
// Per-stage dwell counter: load latches the dwell length and zeroes the count,
// clear restarts the count, inc advances it; expire flags the last cycle of a stage.
module dwell_timer #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_clear,
    input  logic               i_inc,
    output logic               o_expire
);

    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_timer;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dwell <= '0;
            r_timer <= '0;
        end else if (i_load) begin
            r_dwell <= i_dwell;
            r_timer <= '0;
        end else if (i_clear) begin
            r_timer <= '0;
        end else if (i_inc) begin
            r_timer <= r_timer + DWELL_W'(1);
        end
    end

    // Dwell is never loaded as zero, so dwell-1 cannot underflow during a run.
    assign o_expire = (r_timer == (r_dwell - DWELL_W'(1)));

endmodule

// File: rtl/time_lock_seq.sv
// Parametrised time-lock sequencer: NUM_STAGES timed stages qualified by hold,
// with sticky tamper lockout and escalation to lockout after MAX_FAILS failures.
module time_lock_seq
    import time_lock_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned DWELL_W    = 4,
    parameter int unsigned MAX_FAILS  = 3,
    localparam int unsigned SW        = $clog2(NUM_STAGES + 1),
    localparam int unsigned FW        = $clog2(MAX_FAILS + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [DWELL_W-1:0] i_dwell_in,
    input  logic               i_hold,
    input  logic               i_tamper,
    input  logic               i_clear,
    output logic [SW-1:0]      o_stage,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_fail,
    output logic               o_alarm,
    output logic [FW-1:0]      o_fail_cnt
);

    tl_state_e     r_state;
    tl_state_e     w_state_d;
    logic [SW-1:0] r_stage;
    logic [SW-1:0] w_stage_d;
    logic [FW-1:0] r_fail_cnt;
    logic [FW-1:0] w_fail_cnt_d;
    logic [FW-1:0] w_fail_inc;
    logic          w_tmr_load;
    logic          w_tmr_clear;
    logic          w_tmr_inc;
    logic          w_expire;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (w_tmr_load),
        .i_dwell  (i_dwell_in),
        .i_clear  (w_tmr_clear),
        .i_inc    (w_tmr_inc),
        .o_expire (w_expire)
    );

    assign w_fail_inc = (r_fail_cnt == FW'(MAX_FAILS)) ? r_fail_cnt : r_fail_cnt + FW'(1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_stage    <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_stage    <= w_stage_d;
            r_fail_cnt <= w_fail_cnt_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_stage_d    = r_stage;
        w_fail_cnt_d = r_fail_cnt;
        w_tmr_load   = 1'b0;
        w_tmr_clear  = 1'b0;
        w_tmr_inc    = 1'b0;
        if (i_tamper) begin
            w_state_d = LOCKOUT;
            w_stage_d = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start && (i_dwell_in != '0)) begin
                        w_state_d  = RUN;
                        w_stage_d  = SW'(1);
                        w_tmr_load = 1'b1;
                    end
                end
                RUN: begin
                    // Losing hold wins over a coincident expiry.
                    if (!i_hold) begin
                        w_stage_d    = '0;
                        w_fail_cnt_d = w_fail_inc;
                        w_state_d    = (w_fail_inc == FW'(MAX_FAILS)) ? LOCKOUT : FAIL;
                    end else if (w_expire) begin
                        if (r_stage < SW'(NUM_STAGES)) begin
                            w_stage_d   = r_stage + SW'(1);
                            w_tmr_clear = 1'b1;
                        end else begin
                            w_state_d    = DONE;
                            w_stage_d    = '0;
                            w_fail_cnt_d = '0;
                        end
                    end else begin
                        w_tmr_inc = 1'b1;
                    end
                end
                DONE: begin
                    w_fail_cnt_d = '0;
                    if (i_clear) begin
                        w_state_d = IDLE;
                    end
                end
                FAIL: begin
                    if (i_clear) begin
                        w_state_d = IDLE;
                    end
                end
                LOCKOUT: begin
                    w_state_d = LOCKOUT;
                end
                default: begin
                    w_state_d = LOCKOUT;
                    w_stage_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_stage    = '0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_fail     = 1'b0;
        o_alarm    = 1'b0;
        o_fail_cnt = r_fail_cnt;
        case (r_state)
            IDLE: begin
            end
            RUN: begin
                o_busy  = 1'b1;
                o_stage = r_stage;
            end
            DONE: begin
                o_done = 1'b1;
            end
            FAIL: begin
                o_fail = 1'b1;
            end
            default: begin
                o_fail  = 1'b1;
                o_alarm = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_time_lock_seq.sv
// Directed self-checking bench for time_lock_seq with default parameters
// (3 stages, 4-bit dwell, lockout on the third failure).
module tb_time_lock_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] dwell_in;
    logic       hold;
    logic       tamper;
    logic       clear;
    logic [1:0] stage;
    logic       busy;
    logic       done;
    logic       fail;
    logic       alarm;
    logic [1:0] fail_cnt;

    int n_vec;
    int n_err;

    time_lock_seq u_dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_dwell_in (dwell_in),
        .i_hold     (hold),
        .i_tamper   (tamper),
        .i_clear    (clear),
        .o_stage    (stage),
        .o_busy     (busy),
        .o_done     (done),
        .o_fail     (fail),
        .o_alarm    (alarm),
        .o_fail_cnt (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input int e_stage, input int e_busy,
                              input int e_done, input int e_fail, input int e_alarm,
                              input int e_fcnt);
        check_val({tag, ".stage"}, 32'(stage), e_stage);
        check_val({tag, ".busy"}, 32'(busy), e_busy);
        check_val({tag, ".done"}, 32'(done), e_done);
        check_val({tag, ".fail"}, 32'(fail), e_fail);
        check_val({tag, ".alarm"}, 32'(alarm), e_alarm);
        check_val({tag, ".fail_cnt"}, 32'(fail_cnt), e_fcnt);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Outputs must drop asynchronously, before any clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        expect_out(tag, 0, 0, 0, 0, 0, 0);
        cyc(1);
        reset = 1'b0;
    endtask

    task automatic kick(input logic [3:0] d);
        start    = 1'b1;
        dwell_in = d;
        cyc(1);
        start    = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dwell_in = 4'd0;
        hold     = 1'b1;
        tamper   = 1'b0;
        clear    = 1'b0;
        cyc(2);
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc(1);
        expect_out("idle", 0, 0, 0, 0, 0, 0);

        // Clean run, dwell 4: stages 1,2,3 for four cycles each.
        kick(4'd4);
        for (int i = 0; i < 12; i++) begin
            check_val($sformatf("run.c%0d.stage", i), 32'(stage), i / 4 + 1);
            check_val($sformatf("run.c%0d.busy", i), 32'(busy), 1);
            cyc(1);
        end
        expect_out("done", 0, 0, 1, 0, 0, 0);
        start = 1'b1;
        clear = 1'b1;
        cyc(1);
        start = 1'b0;
        clear = 1'b0;
        expect_out("done_clr", 0, 0, 0, 0, 0, 0);
        cyc(1);
        expect_out("done_clr_nostart", 0, 0, 0, 0, 0, 0);

        // Hold drop at RUN cycle 6 (stage 2).
        kick(4'd4);
        cyc(5);
        expect_out("f1_pre", 2, 1, 0, 0, 0, 0);
        hold = 1'b0;
        cyc(1);
        hold = 1'b1;
        expect_out("f1", 0, 0, 0, 1, 0, 1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        expect_out("f1_clr", 0, 0, 0, 0, 0, 1);

        // Second and third failures; third escalates to lockout.
        kick(4'd4);
        hold = 1'b0;
        cyc(1);
        hold = 1'b1;
        expect_out("f2", 0, 0, 0, 1, 0, 2);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        kick(4'd4);
        hold = 1'b0;
        cyc(1);
        hold = 1'b1;
        expect_out("f3_lock", 0, 0, 0, 1, 1, 3);
        clear    = 1'b1;
        start    = 1'b1;
        dwell_in = 4'd4;
        cyc(2);
        clear = 1'b0;
        start = 1'b0;
        expect_out("lock_sticky", 0, 0, 0, 1, 1, 3);
        do_reset("lock_rst");

        // Tamper in IDLE.
        tamper = 1'b1;
        cyc(1);
        tamper = 1'b0;
        expect_out("tmp_idle", 0, 0, 0, 1, 1, 0);
        do_reset("tmp_idle_rst");

        // Tamper in RUN stage 2.
        kick(4'd4);
        cyc(4);
        expect_out("tmp_run_pre", 2, 1, 0, 0, 0, 0);
        tamper = 1'b1;
        cyc(1);
        tamper = 1'b0;
        expect_out("tmp_run", 0, 0, 0, 1, 1, 0);
        do_reset("tmp_run_rst");

        // Tamper in DONE (dwell 1 run).
        kick(4'd1);
        cyc(3);
        expect_out("tmp_done_pre", 0, 0, 1, 0, 0, 0);
        tamper = 1'b1;
        cyc(1);
        tamper = 1'b0;
        expect_out("tmp_done", 0, 0, 0, 1, 1, 0);
        do_reset("tmp_done_rst");

        // Hold drop on the final expiry cycle goes to FAIL, not DONE.
        kick(4'd2);
        cyc(5);
        expect_out("last_pre", 3, 1, 0, 0, 0, 0);
        hold = 1'b0;
        cyc(1);
        hold = 1'b1;
        expect_out("last_fail", 0, 0, 0, 1, 0, 1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;

        // Start with zero dwell is ignored.
        start    = 1'b1;
        dwell_in = 4'd0;
        cyc(2);
        start = 1'b0;
        expect_out("dwell0", 0, 0, 0, 0, 0, 1);

        // Reset mid stage 2, then a dwell-1 run completes in three cycles.
        kick(4'd4);
        cyc(4);
        expect_out("mid_pre", 2, 1, 0, 0, 0, 1);
        do_reset("mid_rst");
        kick(4'd1);
        expect_out("d1_s1", 1, 1, 0, 0, 0, 0);
        dwell_in = 4'd9;
        cyc(1);
        expect_out("d1_s2", 2, 1, 0, 0, 0, 0);
        cyc(1);
        expect_out("d1_s3", 3, 1, 0, 0, 0, 0);
        cyc(1);
        expect_out("d1_done", 0, 0, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/time_lock_seq.md
# time_lock_seq

Parametrised multi-stage time-lock sequencer for the vault unlock path. It generalises the fixed three-stage time lock: the stage count and dwell-counter width are set by parameters, the dwell length is loaded per run, and progress depends on a continuous hold qualifier. A tamper input forces a sticky lockout with alarm, and repeated failures escalate to the same lockout. The downstream phase controller consumes `done`/`fail`/`alarm`.

## Interface
- `NUM_STAGES`, default 3: number of timed stages, ≥1.
- `DWELL_W`, default 4: width of dwell counter and `dwell_in`.
- `MAX_FAILS`, default 3: FAIL entries (without an intervening DONE) that escalate to LOCKOUT, ≥1.
- `SW = $clog2(NUM_STAGES+1)`, `FW = $clog2(MAX_FAILS+1)`: derived widths.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin sequence; sampled only in IDLE.
- `dwell_in`  in  DWELL_W  cycles per stage; latched on accepted start.
- `hold`  in  1  operator qualifier; must stay 1 throughout RUN.
- `tamper`  in  1  tamper detect; highest priority, any state.
- `clear`  in  1  acknowledge; returns DONE/FAIL to IDLE.
- `stage`  out  SW  current stage 1..NUM_STAGES in RUN, else 0.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `fail`  out  1  high in FAIL and LOCKOUT.
- `alarm`  out  1  high in LOCKOUT only.
- `fail_cnt`  out  FW  failures since last DONE or reset.

## Operation
- States: IDLE, RUN, DONE, FAIL, LOCKOUT. All outputs are registered (Moore) and are a function of state, stage and fail_cnt.
- Reset: state=IDLE, stage=0, timer=0, fail_cnt=0. All outputs 0.
- Priority each cycle: tamper, then the per-state rules below.
- tamper=1 in any state → LOCKOUT.
- IDLE:
  - start=1 with dwell_in≠0 → RUN, stage=1, timer=0, dwell latched.
  - start with dwell_in=0 is ignored (stay IDLE).
- RUN:
  - hold=0 → FAIL. This takes priority over expiry in the same cycle.
  - Otherwise, while timer<dwell-1: timer+1.
  - At timer==dwell-1: if stage<NUM_STAGES, stage+1 and timer=0; else → DONE.
- Failure accounting on a RUN→FAIL transition:
  - fail_cnt+1 (saturating).
  - If the new value equals MAX_FAILS, go to LOCKOUT instead of FAIL.
- DONE: fail_cnt=0. clear=1 → IDLE. start is ignored, including when it coincides with clear.
- FAIL: clear=1 → IDLE. fail_cnt is retained.
- LOCKOUT: absorbing. Only reset exits; clear, start and hold are ignored.
- Dwell is fixed for the run. Changes to dwell_in during RUN have no effect.
- Reset mid-RUN returns to IDLE immediately and asynchronously. No done or fail pulse is produced.

## Timing
- Accepted start at edge N gives busy=1 and stage=1 from N+1.
- A clean run occupies exactly NUM_STAGES×dwell cycles in RUN; done=1 follows on the next cycle.
- Stage k is visible for exactly dwell cycles.
- Tamper, hold drop and clear each take effect one edge after they are sampled high (or low, for hold).
- dwell=1: stage advances every cycle.
- The timer never wraps: its maximum is dwell-1 ≤ 2^DWELL_W−2.

## Structure
- Package `time_lock_pkg`: state enum `tl_state_e` (IDLE, RUN, DONE, FAIL, LOCKOUT), 3-bit encoding; unused codes → LOCKOUT.
- One sub-module, `dwell_timer`, is natural. It contains the load/clear/increment counter with an `expire` flag (timer==dwell-1). The FSM and stage counter stay in the top module.

## Test plan
- Reset; start with dwell_in=4, hold=1, defaults → stage 1,2,3 for 4 cycles each (12 RUN cycles), then done=1. clear → IDLE, fail_cnt=0.
- Drop hold at cycle 6 of RUN → fail=1 and fail_cnt=1 next cycle; stage=0. clear → IDLE.
- Three consecutive hold-drop failures (MAX_FAILS=3) → third goes to LOCKOUT with alarm=1; clear/start ignored; only reset clears.
- tamper pulse in IDLE, in RUN stage 2, and in DONE → LOCKOUT, alarm=1 on the next cycle in each case.
- Simultaneous hold=0 on the final expiry cycle → FAIL, not DONE. start with dwell_in=0 → remains IDLE, busy=0.
- Assert reset mid-stage 2 → all outputs 0 immediately; a new run with dwell_in=1 completes in 3 RUN cycles (NUM_STAGES=3).
